// File: rtl/fifo_bus_ctrl_pkg.sv
// rtl/fifo_bus_ctrl_pkg.sv - shared types and default timing for the FT245-style FIFO bus sequencer
package fifo_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSET,
    WSTB,
    WHLD,
    REC
  } state_t;

  typedef enum logic {
    GRANT_RX,
    GRANT_TX
  } grant_t;

  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_SETUP  = 1;
  localparam int DEF_WR_CYCLES = 2;
  localparam int DEF_RECOVER   = 2;
  localparam int DEF_DW        = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_phase_timer.sv
// rtl/fifo_phase_timer.sv - loadable down-counter timing each bus phase; done when it reaches zero
module fifo_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fifo_bus_ctrl.sv
// rtl/fifo_bus_ctrl.sv - arbitrates RX reads and TX writes onto a shared FT245-style FIFO bus
module fifo_bus_ctrl
  import fifo_bus_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WR_SETUP  = DEF_WR_SETUP,
  parameter int WR_CYCLES = DEF_WR_CYCLES,
  parameter int RECOVER   = DEF_RECOVER,
  parameter int DW        = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fifo_rxf,
  input  logic          fifo_txe,
  output logic          fifo_rd,
  output logic          fifo_wr,
  input  logic [DW-1:0] fifo_din,
  output logic [DW-1:0] fifo_dout,
  output logic          fifo_oe,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready
);

  localparam int MAXP = max2(max2(RD_CYCLES, WR_SETUP), max2(WR_CYCLES, RECOVER));
  localparam int PW   = $clog2(MAXP) + 1;

  state_t        state, state_next;
  grant_t        last_grant;
  logic          rx_elig, tx_elig;
  logic          grant_rx, grant_tx;
  logic          timer_load, timer_done;
  logic [PW-1:0] load_value;

  // A consumer handshake this cycle frees the buffer for an immediate new read.
  always_comb begin
    rx_elig  = !fifo_rxf && (!rx_valid || rx_ready);
    tx_elig  = !fifo_txe && tx_valid;
    grant_rx = (state == IDLE) && rx_elig && (!tx_elig || (last_grant == GRANT_TX));
    grant_tx = (state == IDLE) && tx_elig && !grant_rx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (grant_rx) begin
          state_next = RD;
        end else if (grant_tx) begin
          state_next = WSET;
        end
      end
      RD:   if (timer_done) state_next = REC;
      WSET: if (timer_done) state_next = WSTB;
      WSTB: if (timer_done) state_next = WHLD;
      WHLD: state_next = REC;
      REC:  if (timer_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every phase is N cycles long, so the timer is loaded with N-1 on entry.
  always_comb begin
    timer_load = (state_next != state);
    load_value = '0;
    unique case (state_next)
      RD:      load_value = PW'(RD_CYCLES - 1);
      WSET:    load_value = PW'(WR_SETUP - 1);
      WSTB:    load_value = PW'(WR_CYCLES - 1);
      REC:     load_value = PW'(RECOVER - 1);
      default: load_value = '0;
    endcase
  end

  fifo_phase_timer #(
    .W(PW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(load_value),
    .done      (timer_done)
  );

  // Pin outputs are derived from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_rd    <= 1'b1;
      fifo_wr    <= 1'b0;
      fifo_oe    <= 1'b0;
      fifo_dout  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      last_grant <= GRANT_TX;
    end else begin
      fifo_rd  <= (state_next != RD);
      fifo_wr  <= (state_next == WSTB);
      fifo_oe  <= (state_next == WSET) || (state_next == WSTB) || (state_next == WHLD);
      tx_ready <= grant_tx;
      if (grant_tx) begin
        fifo_dout  <= tx_data;
        last_grant <= GRANT_TX;
      end else if (grant_rx) begin
        last_grant <= GRANT_RX;
      end
      if ((state == RD) && timer_done) begin
        rx_data  <= fifo_din;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_bus_ctrl.sv
// tb/tb_fifo_bus_ctrl.sv - self-checking bench for fifo_bus_ctrl against a transaction-schedule model
module tb_fifo_bus_ctrl;

  localparam int DW   = 7;
  localparam int RDC  = 2;
  localparam int WS   = 1;
  localparam int WC   = 2;
  localparam int RCV  = 2;
  localparam int RTOT = RDC + RCV;
  localparam int WTOT = WS + WC + 1 + RCV;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_rxf, fifo_txe;
  logic          fifo_rd, fifo_wr, fifo_oe;
  logic [DW-1:0] fifo_din, fifo_dout;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_ready;

  fifo_bus_ctrl #(
    .RD_CYCLES(RDC),
    .WR_SETUP (WS),
    .WR_CYCLES(WC),
    .RECOVER  (RCV),
    .DW       (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fifo_rxf (fifo_rxf),
    .fifo_txe (fifo_txe),
    .fifo_rd  (fifo_rd),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .fifo_dout(fifo_dout),
    .fifo_oe  (fifo_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a transfer is a schedule of offsets from its grant cycle.
  bit            m_busy, m_write, m_last_tx;
  int            m_k;
  logic          e_rd, e_wr, e_oe, e_rxv, e_txr;
  logic [DW-1:0] e_dout, e_rxd;

  int            rd_lo, wr_hi, oe_hi, txr_cnt;
  logic          prev_rd = 1'b1;
  logic [7:0]    gseq[$];
  int            prod_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit rv, rx_el, tx_el, cap;
    if (reset) begin
      m_busy    = 0;
      m_write   = 0;
      m_k       = 0;
      m_last_tx = 1;
      e_dout    = '0;
      e_rxd     = '0;
      e_rxv     = 1'b0;
    end else begin
      rv  = e_rxv;
      cap = m_busy && !m_write && (m_k == RDC);
      if (cap) begin
        e_rxd = fifo_din;
        e_rxv = 1'b1;
      end else if (rv && rx_ready) begin
        e_rxv = 1'b0;
      end
      if (!m_busy) begin
        rx_el = !fifo_rxf && (!rv || rx_ready);
        tx_el = !fifo_txe && tx_valid;
        if (rx_el && (!tx_el || m_last_tx)) begin
          m_busy = 1; m_write = 0; m_k = 1; m_last_tx = 0;
        end else if (tx_el) begin
          m_busy = 1; m_write = 1; m_k = 1; m_last_tx = 1;
          e_dout = tx_data;
        end
      end else begin
        m_k++;
        if (m_k > (m_write ? WTOT : RTOT)) m_busy = 0;
      end
    end
    e_rd  = !(m_busy && !m_write && m_k <= RDC);
    e_oe  = m_busy && m_write && m_k <= WS + WC + 1;
    e_wr  = m_busy && m_write && m_k > WS && m_k <= WS + WC;
    e_txr = m_busy && m_write && m_k == 1;
  endtask

  // Each iteration: model consumes the inputs in force, then the next negedge arrives.
  task automatic step(input int n);
    repeat (n) begin
      model_update();
      @(negedge clk);
      if (tx_ready) begin
        case (prod_mode)
          1: tx_data = DW'($urandom);
          2: begin tx_valid = 1'b0; fifo_txe = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic clr_counts();
    rd_lo = 0; wr_hi = 0; oe_hi = 0; txr_cnt = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("fifo_rd",   32'(fifo_rd),   32'(e_rd));
      chk("fifo_wr",   32'(fifo_wr),   32'(e_wr));
      chk("fifo_oe",   32'(fifo_oe),   32'(e_oe));
      chk("fifo_dout", 32'(fifo_dout), 32'(e_dout));
      chk("rx_data",   32'(rx_data),   32'(e_rxd));
      chk("rx_valid",  32'(rx_valid),  32'(e_rxv));
      chk("tx_ready",  32'(tx_ready),  32'(e_txr));
      chk("oe_during_rd", 32'(fifo_oe && !fifo_rd), 32'(0));
      if (!fifo_rd) rd_lo++;
      if (fifo_wr) wr_hi++;
      if (fifo_oe) oe_hi++;
      if (tx_ready) begin
        txr_cnt++;
        gseq.push_back(8'h54);
      end
      if (prev_rd && !fifo_rd) gseq.push_back(8'h52);
      prev_rd = fifo_rd;
    end
  end

  initial begin
    string exp_s;
    bit    seen;
    reset = 1'b1; fifo_rxf = 1'b1; fifo_txe = 1'b1; fifo_din = '0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    clr_counts();
    step(3);

    // Single read of 0x41 with the consumer stalled afterwards.
    reset = 1'b0; fifo_rxf = 1'b0; fifo_din = 7'h41;
    clr_counts();
    step(10);
    chk("read_rd_low_cycles", 32'(rd_lo), 32'd2);
    chk("read_oe_cycles", 32'(oe_hi), 32'd0);
    chk("read_rx_data", 32'(rx_data), 32'h41);
    chk("read_rx_valid", 32'(rx_valid), 32'd1);

    // Full buffer blocks reads until a one-cycle consumer handshake.
    clr_counts();
    step(8);
    chk("full_no_read", 32'(rd_lo), 32'd0);
    fifo_din = 7'h15; rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(10);
    chk("one_more_read", 32'(rd_lo), 32'd2);
    chk("second_rx_data", 32'(rx_data), 32'h15);

    // Write of 0x0D; txe rises during setup, valid drops after tx_ready.
    fifo_rxf = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 7'h0D; fifo_txe = 1'b0;
    prod_mode = 2;
    clr_counts();
    step(12);
    chk("write_tx_ready_pulses", 32'(txr_cnt), 32'd1);
    chk("write_wr_high_cycles", 32'(wr_hi), 32'd2);
    chk("write_oe_cycles", 32'(oe_hi), 32'd4);
    chk("write_dout", 32'(fifo_dout), 32'h0D);

    // Reset during the second strobe cycle of a write.
    prod_mode = 0; tx_valid = 1'b1; tx_data = 7'h55; fifo_txe = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (fifo_wr) seen = 1;
    end
    chk("wstb_seen", 32'(seen), 32'd1);
    step(1);
    chk("wstb_second_cycle", 32'(fifo_wr), 32'd1);
    reset = 1'b1; fifo_rxf = 1'b0;
    step(1);
    chk("reset_wr", 32'(fifo_wr), 32'd0);
    chk("reset_oe", 32'(fifo_oe), 32'd0);
    chk("reset_rd", 32'(fifo_rd), 32'd1);

    // Both sides eligible continuously: grants must alternate starting with RX.
    reset = 1'b0; prod_mode = 1;
    gseq.delete();
    step(40);
    exp_s = "RTRT";
    chk("grant_count", 32'(gseq.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("grant_seq%0d", i), 32'(gseq[i]), 32'(exp_s[i]));
    end

    // Random traffic, including occasional resets.
    prod_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 149) == 0);
      fifo_rxf = ($urandom_range(0, 9) < 4);
      fifo_txe = ($urandom_range(0, 9) < 4);
      fifo_din = DW'($urandom);
      rx_ready = ($urandom_range(0, 9) < 5);
      tx_valid = ($urandom_range(0, 9) < 6);
      tx_data  = DW'($urandom);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_bus_ctrl.md
Name: fifo_bus_ctrl

Overview:
- Sequences the shared FT245-style USB FIFO bus between two requesters.
- RX path: a keyboard-side consumer takes bytes from the FIFO.
- TX path: a display-side producer pushes bytes into the FIFO.
- Generates RD/WR strobes with programmable pulse, setup, hold and recovery timing, owns the data-bus output enable, and round-robin arbitrates when both sides are eligible. Sits between the PIA glue logic and the FIFO pins.

Parameters:
- RD_CYCLES, 2, cycles fifo_rd is held low; data sampled on last one; must be >=1.
- WR_SETUP, 1, cycles data is driven before fifo_wr rises; must be >=1.
- WR_CYCLES, 2, cycles fifo_wr is held high; must be >=1.
- RECOVER, 2, idle cycles after every transfer; also the bus turnaround; must be >=1.
- DW, 7, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- fifo_rxf  in  1  active-low: FIFO has RX data.
- fifo_txe  in  1  active-low: FIFO can accept TX data.
- fifo_rd  out  1  active-low read strobe.
- fifo_wr  out  1  active-high write strobe; FIFO latches on falling edge.
- fifo_din  in  DW  data from the pad.
- fifo_dout  out  DW  data to the pad.
- fifo_oe  out  1  pad output enable.
- rx_data  out  DW  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid && rx_ready.
- tx_data  in  DW  byte to send.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  single-cycle pulse; tx_data is captured this cycle.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous, active-high, and wins over all other activity.
- Reset values:
  - fifo_rd=1, fifo_wr=0, fifo_oe=0.
  - fifo_dout=0, rx_data=0, rx_valid=0, tx_ready=0.
  - state=IDLE, last_grant=TX, so RX wins the first tie.
- Eligibility, evaluated in IDLE:
  - rx_elig = !fifo_rxf && !rx_valid.
  - tx_elig = !fifo_txe && tx_valid.
  - An asserted rx_ready in the same cycle counts as the buffer being emptied; rx_elig uses the post-handshake rx_valid.
- Arbitration, in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the side opposite last_grant.
  - On grant, update last_grant.
- States:
  - IDLE: on an RX grant, go to RD. On a TX grant, pulse tx_ready, latch tx_data into fifo_dout, go to WSET.
  - RD: fifo_rd=0 for exactly RD_CYCLES cycles. On the last cycle, rx_data<=fifo_din and rx_valid<=1, effective the next cycle. Then go to REC.
  - WSET: fifo_oe=1 and fifo_wr=0 for WR_SETUP cycles, then go to WSTB.
  - WSTB: fifo_oe=1 and fifo_wr=1 for WR_CYCLES cycles, then go to WHLD.
  - WHLD: fifo_wr=0 and fifo_oe=1 for one cycle (data hold past the falling edge), then go to REC.
  - REC: all strobes inactive, fifo_oe=0, for RECOVER cycles, then go to IDLE.
- Outputs are registered. fifo_rd falls on the cycle after the IDLE grant cycle.
- Latency:
  - Read: RD_CYCLES+1 cycles from grant to rx_valid.
  - Write: WR_SETUP+WR_CYCLES+1 cycles from grant to end of hold.
- Invariant: fifo_oe is never 1 while fifo_rd=0. At least one REC cycle with fifo_oe=0 separates any write from a following read.
- Requester changes mid-transfer:
  - fifo_rxf/fifo_txe changing mid-transfer are ignored; the transfer completes.
  - A tx_valid drop after the grant has no effect, since the data is already latched.
- rx_valid clears on the rx_valid&&rx_ready cycle. It may clear in any state. A new read is only granted once the buffer is empty.
- Reset mid-transfer: return to IDLE with all outputs at reset values next cycle. A partially read byte is discarded; a partially written byte may be lost.
- Phase counter: down-counter of width $clog2(max param)+1, loaded with N-1 on state entry.

Decomposition:
- fifo_bus_ctrl_pkg holds:
  - state typedef: IDLE, RD, WSET, WSTB, WHLD, REC.
  - grant typedef: GRANT_RX, GRANT_TX.
  - default timing constants.
- One sub-module: fifo_phase_timer. It is a loadable down-counter with load, load_value and a done flag, instanced once and shared by all timed states.

Test Plan (default parameters):
- Reset, then fifo_rxf=0, fifo_din=7'h41 → fifo_rd low for exactly 2 cycles starting 1 cycle after grant; rx_data=7'h41 and rx_valid=1 after the strobe; 2 recovery cycles follow; fifo_oe stays 0 throughout.
- tx_valid=1, tx_data=7'h0D, fifo_txe=0 → tx_ready pulses 1 cycle; fifo_oe=1 with fifo_dout=7'h0D for 1 setup, 2 strobe and 1 hold cycles; fifo_wr high exactly 2 cycles; fifo_oe=0 in recovery.
- Both eligible continuously, consumer always ready → grants alternate RX, TX, RX, TX starting with RX; no fifo_rd=0 cycle has fifo_oe=1.
- rx_valid=1, rx_ready=0, fifo_rxf=0 → no read is issued. Raise rx_ready for 1 cycle → exactly one new read starts.
- Assert reset during the 2nd cycle of WSTB → next cycle fifo_wr=0, fifo_oe=0, state IDLE. After release with both eligible, RX is granted first.
- fifo_txe goes high during WSET → the write still completes the full WSET/WSTB/WHLD sequence; no extra tx_ready pulse.
